// File: rtl/ddr_sram_arb_pkg.sv
// Shared definitions for the three-client SRAM-port arbiter.
// Contents: requester id type and constants, command type, request decode helper.
package ddr_sram_arb_pkg;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_PRIO  = 2'd0;
    localparam req_id_t REQ_LOW_A = 2'd1;
    localparam req_id_t REQ_LOW_B = 2'd2;

    typedef enum logic [1:0] {
        CmdNone  = 2'd0,
        CmdRead  = 2'd1,
        CmdWrite = 2'd2
    } cmd_e;

    // A request with both strobes high is a write; the read strobe is ignored.
    function automatic cmd_e decode_cmd(input logic rd, input logic wr);
        cmd_e cmd;
        cmd = CmdNone;
        if (wr) begin
            cmd = CmdWrite;
        end else if (rd) begin
            cmd = CmdRead;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ddr_sram_read_tracker.sv
// Delay line of {valid, id} matching the controller read latency.
// Ports:
//   drm_clock, drm_ctl_reset_n : clock, asynchronous active-low reset
//   push_valid, push_id        : an accepted read entering the line this cycle
//   valid_onehot               : per-requester read-data-valid, from the last stage
module ddr_sram_read_tracker
    import ddr_sram_arb_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic       drm_clock,
    input  logic       drm_ctl_reset_n,
    input  logic       push_valid,
    input  req_id_t    push_id,
    output logic [2:0] valid_onehot
);

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } entry_t;

    entry_t line_q [READ_LATENCY];

    always_ff @(posedge drm_clock or negedge drm_ctl_reset_n) begin
        if (!drm_ctl_reset_n) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q[0] <= '{valid: push_valid, id: push_id};
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    always_comb begin
        valid_onehot = 3'b000;
        if (line_q[READ_LATENCY-1].valid) begin
            case (line_q[READ_LATENCY-1].id)
                REQ_PRIO:  valid_onehot = 3'b001;
                REQ_LOW_A: valid_onehot = 3'b010;
                REQ_LOW_B: valid_onehot = 3'b100;
                default:   valid_onehot = 3'b000;
            endcase
        end
    end

endmodule

// File: rtl/ddr_sram_arbiter.sv
// Shares the SRAM-style port of ddr_dram_as_sram between three requesters.
// Requester 0 is the priority client; requesters 1 and 2 are served round-robin.
// Ports:
//   drm_clock, drm_ctl_reset_n          : clock, asynchronous active-low reset
//   reqN_read/_write/_address/
//   _write_data/_byte_enables           : requester commands, held until reqN_ack
//   reqN_ack                            : combinational, command captured this cycle
//   reqN_read_data_valid, read_data     : routed read return
//   sram_*                              : registered issue stage towards the controller
//   sram_read_data, sram_low_priority_wait : controller read data and low-priority stall
module ddr_sram_arbiter
    import ddr_sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 24,
    parameter int unsigned READ_LATENCY   = 4,
    parameter int unsigned PRIO_BURST_MAX = 8
) (
    input  logic              drm_clock,
    input  logic              drm_ctl_reset_n,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic [31:0]       req0_write_data,
    input  logic [3:0]        req0_byte_enables,
    output logic              req0_ack,
    output logic              req0_read_data_valid,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic [31:0]       req1_write_data,
    input  logic [3:0]        req1_byte_enables,
    output logic              req1_ack,
    output logic              req1_read_data_valid,
    input  logic              req2_read,
    input  logic              req2_write,
    input  logic [ADDR_W-1:0] req2_address,
    input  logic [31:0]       req2_write_data,
    input  logic [3:0]        req2_byte_enables,
    output logic              req2_ack,
    output logic              req2_read_data_valid,
    output logic [31:0]       read_data,
    output logic              sram_priority,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_address,
    output logic [31:0]       sram_write_data,
    output logic [3:0]        sram_write_byte_enables,
    input  logic [31:0]       sram_read_data,
    input  logic              sram_low_priority_wait
);

    localparam int unsigned BURST_W = $clog2(PRIO_BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(PRIO_BURST_MAX);

    logic [2:0] pending;
    logic       stall, can_load, low_pending, force_low, grant;
    req_id_t    winner, low_winner;
    cmd_e       win_cmd;

    logic              win_rd, win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic [3:0]        win_be;

    logic              cmd_valid_q, cmd_valid_d;
    logic              prio_q, prio_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    req_id_t           id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    req_id_t           rr_q, rr_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    assign pending = {req2_read | req2_write, req1_read | req1_write, req0_read | req0_write};

    // Arbitration and winner field selection.
    always_comb begin
        stall       = cmd_valid_q & ~prio_q & sram_low_priority_wait;
        can_load    = ~stall;
        low_pending = pending[1] | pending[2];
        force_low   = low_pending && (burst_q == BURST_LIMIT);

        if (rr_q == REQ_LOW_A) begin
            low_winner = pending[1] ? REQ_LOW_A : REQ_LOW_B;
        end else begin
            low_winner = pending[2] ? REQ_LOW_B : REQ_LOW_A;
        end

        grant  = 1'b0;
        winner = REQ_PRIO;
        if (can_load) begin
            if (pending[0] && !force_low) begin
                grant  = 1'b1;
                winner = REQ_PRIO;
            end else if (low_pending) begin
                grant  = 1'b1;
                winner = low_winner;
            end
        end

        case (winner)
            REQ_LOW_A: begin
                win_rd    = req1_read;
                win_wr    = req1_write;
                win_addr  = req1_address;
                win_wdata = req1_write_data;
                win_be    = req1_byte_enables;
            end
            REQ_LOW_B: begin
                win_rd    = req2_read;
                win_wr    = req2_write;
                win_addr  = req2_address;
                win_wdata = req2_write_data;
                win_be    = req2_byte_enables;
            end
            default: begin
                win_rd    = req0_read;
                win_wr    = req0_write;
                win_addr  = req0_address;
                win_wdata = req0_write_data;
                win_be    = req0_byte_enables;
            end
        endcase
        win_cmd = decode_cmd(win_rd, win_wr);
    end

    // Issue stage, round-robin pointer and priority burst counter next state.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        prio_d      = prio_q;
        read_d      = read_q;
        write_d     = write_q;
        id_d        = id_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rr_d        = rr_q;
        burst_d     = burst_q;

        if (can_load) begin
            cmd_valid_d = grant;
            prio_d      = grant && (winner == REQ_PRIO);
            read_d      = grant && (win_cmd == CmdRead);
            write_d     = grant && (win_cmd == CmdWrite);
            id_d        = winner;
            addr_d      = grant ? win_addr  : '0;
            wdata_d     = grant ? win_wdata : '0;
            be_d        = grant ? win_be    : '0;
        end

        if (grant && (winner != REQ_PRIO)) begin
            rr_d = (winner == REQ_LOW_A) ? REQ_LOW_B : REQ_LOW_A;
        end

        if (!low_pending || (grant && (winner != REQ_PRIO))) begin
            burst_d = '0;
        end else if (grant && (burst_q != BURST_LIMIT)) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge drm_clock or negedge drm_ctl_reset_n) begin
        if (!drm_ctl_reset_n) begin
            cmd_valid_q <= 1'b0;
            prio_q      <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            id_q        <= REQ_PRIO;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rr_q        <= REQ_LOW_A;
            burst_q     <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            prio_q      <= prio_d;
            read_q      <= read_d;
            write_q     <= write_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rr_q        <= rr_d;
            burst_q     <= burst_d;
        end
    end

    // Acks are combinational from held requests, so keep them quiet while in reset.
    assign req0_ack = grant && (winner == REQ_PRIO)  && drm_ctl_reset_n;
    assign req1_ack = grant && (winner == REQ_LOW_A) && drm_ctl_reset_n;
    assign req2_ack = grant && (winner == REQ_LOW_B) && drm_ctl_reset_n;

    assign sram_priority           = prio_q;
    assign sram_read               = read_q;
    assign sram_write              = write_q;
    assign sram_address            = addr_q;
    assign sram_write_data         = wdata_q;
    assign sram_write_byte_enables = be_q;
    assign read_data               = sram_read_data;

    logic [2:0] rd_valid;

    ddr_sram_read_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_read_tracker (
        .drm_clock       (drm_clock),
        .drm_ctl_reset_n (drm_ctl_reset_n),
        .push_valid      (cmd_valid_q & ~stall & read_q),
        .push_id         (id_q),
        .valid_onehot    (rd_valid)
    );

    assign req0_read_data_valid = rd_valid[0];
    assign req1_read_data_valid = rd_valid[1];
    assign req2_read_data_valid = rd_valid[2];

endmodule

// File: tb/tb_ddr_sram_arbiter.sv
// Self-checking bench for ddr_sram_arbiter: directed arbitration scenarios plus a
// read-return scoreboard that supplies controller read data and checks routing.
module tb_ddr_sram_arbiter;
    import ddr_sram_arb_pkg::*;

    localparam int unsigned ADDR_W         = 24;
    localparam int unsigned READ_LATENCY   = 4;
    localparam int unsigned PRIO_BURST_MAX = 8;

    logic              drm_clock = 1'b0;
    logic              drm_ctl_reset_n;
    logic [2:0]        rq_read, rq_write;
    logic [ADDR_W-1:0] rq_addr  [3];
    logic [31:0]       rq_wdata [3];
    logic [3:0]        rq_be    [3];
    logic              req0_ack, req1_ack, req2_ack;
    logic              vld0, vld1, vld2;
    logic [31:0]       read_data, sram_read_data, sram_write_data;
    logic              sram_priority, sram_read, sram_write, sram_low_priority_wait;
    logic [ADDR_W-1:0] sram_address;
    logic [3:0]        sram_write_byte_enables;
    logic [2:0]        ack_vec, vld_vec;

    assign ack_vec = {req2_ack, req1_ack, req0_ack};
    assign vld_vec = {vld2, vld1, vld0};

    always #5 drm_clock = ~drm_clock;

    ddr_sram_arbiter #(
        .ADDR_W         (ADDR_W),
        .READ_LATENCY   (READ_LATENCY),
        .PRIO_BURST_MAX (PRIO_BURST_MAX)
    ) dut (
        .drm_clock               (drm_clock),
        .drm_ctl_reset_n         (drm_ctl_reset_n),
        .req0_read               (rq_read[0]),
        .req0_write              (rq_write[0]),
        .req0_address            (rq_addr[0]),
        .req0_write_data         (rq_wdata[0]),
        .req0_byte_enables       (rq_be[0]),
        .req0_ack                (req0_ack),
        .req0_read_data_valid    (vld0),
        .req1_read               (rq_read[1]),
        .req1_write              (rq_write[1]),
        .req1_address            (rq_addr[1]),
        .req1_write_data         (rq_wdata[1]),
        .req1_byte_enables       (rq_be[1]),
        .req1_ack                (req1_ack),
        .req1_read_data_valid    (vld1),
        .req2_read               (rq_read[2]),
        .req2_write              (rq_write[2]),
        .req2_address            (rq_addr[2]),
        .req2_write_data         (rq_wdata[2]),
        .req2_byte_enables       (rq_be[2]),
        .req2_ack                (req2_ack),
        .req2_read_data_valid    (vld2),
        .read_data               (read_data),
        .sram_priority           (sram_priority),
        .sram_read               (sram_read),
        .sram_write              (sram_write),
        .sram_address            (sram_address),
        .sram_write_data         (sram_write_data),
        .sram_write_byte_enables (sram_write_byte_enables),
        .sram_read_data          (sram_read_data),
        .sram_low_priority_wait  (sram_low_priority_wait)
    );

    typedef struct {
        req_id_t     id;
        int unsigned due;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     exp_q [$];
    int unsigned cyc = 0;
    logic [31:0] rd_tag = 32'h1000;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rd_seen = 0;

    always @(posedge drm_clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard: an acked read is expected back READ_LATENCY cycles after the
    // acceptance cycle that follows the ack; its data is driven on that cycle.
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge drm_clock);
            #1;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) sram_read_data = exp_q[0].data;
            else sram_read_data = 32'hDEAD_BEEF;
            @(negedge drm_clock);
            if (vld_vec != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check_eq("rd_spurious", vld_vec, 3'b000);
                end else begin
                    e = exp_q.pop_front();
                    rd_seen++;
                    check_eq("rd_id", vld_vec, 3'b001 << e.id);
                    check_eq("rd_due", cyc, e.due);
                    check_eq("rd_data", read_data, e.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check_eq("rd_missing", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (drm_ctl_reset_n) begin
                for (int n = 0; n < 3; n++) begin
                    if (ack_vec[n] && rq_read[n] && !rq_write[n]) begin
                        exp_q.push_back('{id: req_id_t'(n), due: cyc + 1 + READ_LATENCY,
                                          data: rd_tag});
                        rd_tag = rd_tag + 1;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded limit 100000", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge drm_clock);
        #2;
    endtask

    task automatic smp();
        @(negedge drm_clock);
    endtask

    task automatic do_reset();
        step();
        drm_ctl_reset_n        = 1'b0;
        rq_read                = '0;
        rq_write               = '0;
        sram_low_priority_wait = 1'b0;
        exp_q.delete();
        step();
        drm_ctl_reset_n = 1'b1;
    endtask

    task automatic wait_drain();
        int unsigned budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            step();
            budget++;
        end
        if (exp_q.size() != 0) check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"}, ack_vec, 3'b000);
        check_eq({tag, "_vld"}, vld_vec, 3'b000);
        check_eq({tag, "_cmd"}, {sram_priority, sram_read, sram_write}, 3'b000);
        check_eq({tag, "_addr"}, sram_address, 0);
        check_eq({tag, "_wdata"}, sram_write_data, 0);
        check_eq({tag, "_be"}, sram_write_byte_enables, 0);
    endtask

    initial begin
        int seen0;
        drm_ctl_reset_n        = 1'b0;
        rq_read                = 3'b010;
        rq_write               = '0;
        sram_low_priority_wait = 1'b0;
        sram_read_data         = '0;
        for (int n = 0; n < 3; n++) begin
            rq_addr[n]  = '0;
            rq_wdata[n] = '0;
            rq_be[n]    = '0;
        end
        rq_addr[1] = 24'h000010;

        // Reset with req1 read held, then release.
        smp();
        check_all_zero("rst");
        step();
        drm_ctl_reset_n = 1'b1;
        smp();
        check_eq("t1_ack", ack_vec, 3'b010);
        step();
        rq_read = '0;
        smp();
        check_eq("t1_cmd", {sram_read, sram_write, sram_priority}, 3'b100);
        check_eq("t1_addr", sram_address, 24'h000010);
        wait_drain();

        // Round-robin between req1 and req2.
        do_reset();
        step();
        rq_read    = 3'b110;
        rq_addr[1] = 24'h000020;
        rq_addr[2] = 24'h000030;
        for (int i = 0; i < 6; i++) begin
            smp();
            check_eq("t2_ack", ack_vec, (i % 2 == 0) ? 3'b010 : 3'b100);
            check_eq("t2_prio", sram_priority, 1'b0);
            step();
        end
        rq_read = '0;
        wait_drain();

        // Priority burst limit with req0 reads and req1 writes both pending.
        do_reset();
        step();
        rq_read     = 3'b001;
        rq_write    = 3'b010;
        rq_addr[0]  = 24'h000040;
        rq_addr[1]  = 24'h000050;
        rq_wdata[1] = 32'hCAFE_0001;
        rq_be[1]    = 4'hF;
        for (int i = 0; i < 20; i++) begin
            smp();
            check_eq("t3_ack", ack_vec,
                     (i % (PRIO_BURST_MAX + 1) == PRIO_BURST_MAX) ? 3'b010 : 3'b001);
            if (i > 0) begin
                check_eq("t3_prio", sram_priority,
                         ((i - 1) % (PRIO_BURST_MAX + 1) != PRIO_BURST_MAX) ? 1'b1 : 1'b0);
            end
            step();
        end
        rq_read  = '0;
        rq_write = '0;
        wait_drain();

        // Low-priority write held by the controller for five cycles.
        do_reset();
        step();
        rq_write    = 3'b010;
        rq_addr[1]  = 24'h000123;
        rq_wdata[1] = 32'h55AA_1234;
        rq_be[1]    = 4'h5;
        smp();
        check_eq("t4_ack1", ack_vec, 3'b010);
        step();
        rq_write               = '0;
        rq_read                = 3'b001;
        rq_addr[0]             = 24'h000400;
        sram_low_priority_wait = 1'b1;
        for (int k = 0; k < 5; k++) begin
            smp();
            check_eq("t4_hold_ack", ack_vec, 3'b000);
            check_eq("t4_hold_cmd", {sram_write, sram_read, sram_priority}, 3'b100);
            check_eq("t4_hold_addr", sram_address, 24'h000123);
            check_eq("t4_hold_wdata", sram_write_data, 32'h55AA_1234);
            check_eq("t4_hold_be", sram_write_byte_enables, 4'h5);
            step();
        end
        sram_low_priority_wait = 1'b0;
        smp();
        check_eq("t4_ack0", ack_vec, 3'b001);
        check_eq("t4_accept_cmd", {sram_write, sram_read}, 2'b10);
        step();
        rq_read = '0;
        smp();
        check_eq("t4_prio_cmd", {sram_read, sram_priority}, 2'b11);
        check_eq("t4_prio_addr", sram_address, 24'h000400);
        wait_drain();

        // Interleaved reads: data 0xA, 0xB, 0xC routed to 0, 2, 0.
        do_reset();
        rd_tag = 32'hA;
        seen0  = rd_seen;
        step();
        rq_read    = 3'b001;
        rq_addr[0] = 24'h000100;
        smp();
        check_eq("t5_ack_a", ack_vec, 3'b001);
        step();
        rq_read    = 3'b100;
        rq_addr[2] = 24'h000200;
        smp();
        check_eq("t5_ack_b", ack_vec, 3'b100);
        step();
        rq_read    = 3'b001;
        rq_addr[0] = 24'h000104;
        smp();
        check_eq("t5_ack_c", ack_vec, 3'b001);
        step();
        rq_read = '0;
        wait_drain();
        check_eq("t5_returns", rd_seen - seen0, 3);

        // Reset with two reads in flight: nothing may come back.
        do_reset();
        step();
        rq_read    = 3'b010;
        rq_addr[1] = 24'h000300;
        smp();
        check_eq("t6_ack1", ack_vec, 3'b010);
        step();
        rq_read    = 3'b100;
        rq_addr[2] = 24'h000304;
        smp();
        check_eq("t6_ack2", ack_vec, 3'b100);
        step();
        rq_read = '0;
        smp();
        step();
        drm_ctl_reset_n = 1'b0;
        exp_q.delete();
        smp();
        check_all_zero("t6_rst");
        step();
        smp();
        check_all_zero("t6_rst2");
        step();
        drm_ctl_reset_n = 1'b1;
        for (int k = 0; k < int'(READ_LATENCY) + 4; k++) begin
            smp();
            check_eq("t6_no_vld", vld_vec, 3'b000);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
